arb_req_buffer: RTL and testbench
=================================

Name: arb_req_buffer

Overview:
- Four-channel request buffer that sits directly upstream of the 4-way rotating-priority arbiter.
- Queues per-requester transactions in small FIFOs and drives the arbiter's req[3:0] and en from FIFO non-empty status and output-stage availability.
- Consumes the returned one-hot gnt[3:0], pops the granted head into a registered output stage with valid/ready handshake, tagged with the source channel.

Parameters:
DATA_W, 8, payload width per channel
DEPTH, 4, entries per channel FIFO; power of 2, >= 2

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
in_valid  input  4  per-channel push request
in_data  input  4*DATA_W  channel i payload at [i*DATA_W +: DATA_W]
in_ready  output  4  per-channel FIFO not full
arb_req  output  4  to arbiter req; bit i = FIFO i non-empty
arb_en  output  1  to arbiter en; output stage can accept this cycle
arb_gnt  input  4  from arbiter gnt; expected one-hot or zero
out_valid  output  1  output register holds a transaction
out_data  output  DATA_W  granted payload
out_src  output  2  index of granted channel
out_ready  input  1  downstream accepts out_data this cycle
gnt_err  output  1  sticky protocol-error flag

Behaviour:
- Reset is synchronous, active-high, on clock. It is decided and applies to every register.
- Reset clears all FIFOs to empty (pointers and count 0), out_valid=0, out_data=0, out_src=0, gnt_err=0.
- Reset asserted mid-transfer discards all queued and registered data. No in_valid is accepted during a reset cycle.
- FIFO i:
  - Occupancy counter is $clog2(DEPTH)+1 bits; read/write pointers are $clog2(DEPTH) bits and wrap naturally.
  - in_ready[i] = (count_i != DEPTH). Full blocks a push even if a pop happens in the same cycle.
  - Push when in_valid[i] && in_ready[i].
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
- arb_req = ~empty[3:0], combinational from registered counts.
- arb_en = !out_valid || out_ready.
- Grant acceptance, all combinational in the same cycle:
  - grant_ok = arb_en && (arb_gnt is exactly one-hot) && arb_req[idx].
  - On grant_ok, pop FIFO idx. Next edge: out_data <= head_idx, out_src <= idx, out_valid <= 1.
  - If no grant_ok and out_valid && out_ready: out_valid <= 0. out_data and out_src hold their last values.
  - If out_valid && !out_ready: output holds and arb_en=0, so any gnt is ignored.
- gnt_err is set to 1 and held until reset when, with arb_en=1, either:
  - arb_gnt has more than one bit set, or
  - arb_gnt selects a channel with arb_req=0.
  The offending grant pops nothing.
- arb_gnt is ignored entirely while arb_en=0.
- Minimum latency: push accepted at edge N → arb_req high in cycle after N → out_valid high after edge N+1 if granted.
- Throughput: one transaction per cycle when out_ready is held high.

Optional Feature:
- Macro: ARB_BUF_STATS_EN
- Defined:
  - Adds output port grant_stats (32 bits): four 8-bit counters, channel i at [8*i +: 8].
  - Counter i increments on each grant_ok to channel i and saturates at 255.
  - Cleared by reset.
- Undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then in_valid=4'b0001 with in_data ch0=8'hA5 for one cycle; arbiter grants ch0; out_ready=1 → arb_req=0001 one cycle after the push, then out_valid=1, out_data=A5, out_src=0; FIFO0 empty.
- Push 4 entries into ch2 (DEPTH=4) with arb_en forced low by out_valid=1, out_ready=0 → in_ready[2]=0 after the 4th push; a 5th push is dropped; draining yields all 4 in FIFO order.
- All four channels loaded with 2 entries each, out_ready=1 continuously → 8 consecutive out_valid cycles; out_src order matches the arbiter grant rotation; no gnt_err.
- out_ready=0 while out_valid=1 for 3 cycles, arbiter presenting gnt=0010 → out_data and out_src stable, FIFO1 count unchanged, then resumes when out_ready=1.
- Inject arb_gnt=4'b0110, then arb_gnt=4'b1000 with FIFO3 empty, arb_en=1 → gnt_err=1 from the next edge and held; no FIFO pops; reset clears gnt_err.
- With ARB_BUF_STATS_EN defined: 300 grants to ch1 → grant_stats[15:8]=255, other bytes match their grant counts.

Source files
------------

// File: rtl/arb_req_buffer.sv
// arb_req_buffer: four per-channel FIFOs driving a 4-way arbiter, granted head popped into a
// registered valid/ready output stage. Define ARB_BUF_STATS_EN to add saturating grant counters.
module arb_req_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [3:0]          in_valid,
   input  logic [4*DATA_W-1:0] in_data,
   output logic [3:0]          in_ready,
   output logic [3:0]          arb_req,
   output logic                arb_en,
   input  logic [3:0]          arb_gnt,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   output logic [1:0]          out_src,
   input  logic                out_ready,
   output logic                gnt_err
`ifdef ARB_BUF_STATS_EN
   ,
   output logic [31:0]         grant_stats
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_W-1:0] head_data [4];
   logic [3:0]        pop;
   logic [1:0]        gnt_idx;
   logic              gnt_onehot;
   logic              grant_ok;
   logic              grant_bad;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [1:0]        out_src_q, out_src_d;
   logic              gnt_err_q, gnt_err_d;

   assign arb_en = !out_valid_q || out_ready;

   // Any non-zero grant seen while enabled that cannot be honoured is a protocol error.
   always_comb begin
      gnt_idx = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (arb_gnt[k]) gnt_idx = 2'(k);
      end
      gnt_onehot = (arb_gnt != 4'd0) && ((arb_gnt & (arb_gnt - 4'd1)) == 4'd0);
      grant_ok   = arb_en && gnt_onehot && arb_req[gnt_idx];
      grant_bad  = arb_en && (arb_gnt != 4'd0) && !grant_ok;
   end

   assign pop = grant_ok ? (4'b0001 << gnt_idx) : 4'b0000;

   for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      logic [DATA_W-1:0] mem_q [DEPTH];
      logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]     count_q, count_d;
      logic              push;

      assign in_ready[gi]  = (count_q != FULL_CNT);
      assign arb_req[gi]   = (count_q != '0);
      assign push          = in_valid[gi] && in_ready[gi];
      assign head_data[gi] = mem_q[rd_ptr_q];

      always_comb begin
         wr_ptr_d = wr_ptr_q + PW'(push);
         rd_ptr_d = rd_ptr_q + PW'(pop[gi]);
         count_d  = count_q + CW'(push) - CW'(pop[gi]);
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
         end
      end

      // Storage needs no reset: pointers and count define which entries are live.
      always_ff @(posedge clock) begin
         if (push && !reset) begin
            mem_q[wr_ptr_q] <= in_data[gi*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      gnt_err_d   = gnt_err_q || grant_bad;
      if (grant_ok) begin
         out_valid_d = 1'b1;
         out_data_d  = head_data[gnt_idx];
         out_src_d   = gnt_idx;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= 2'd0;
         gnt_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         gnt_err_q   <= gnt_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign gnt_err   = gnt_err_q;

`ifdef ARB_BUF_STATS_EN
   for (genvar gi = 0; gi < 4; gi++) begin : g_stats
      logic [7:0] stat_q, stat_d;

      always_comb begin
         stat_d = stat_q;
         if (pop[gi] && (stat_q != 8'hFF)) stat_d = stat_q + 8'd1;
      end

      always_ff @(posedge clock) begin
         if (reset) stat_q <= 8'd0;
         else       stat_q <= stat_d;
      end

      assign grant_stats[8*gi +: 8] = stat_q;
   end
`endif

endmodule

// File: tb/tb_arb_req_buffer.sv
// Testbench for arb_req_buffer: directed scenarios plus randomized traffic checked against
// a queue-based reference model; the bench also plays the rotating-priority arbiter.
module tb_arb_req_buffer;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_ready;
   logic [3:0]  arb_req;
   logic        arb_en;
   logic [3:0]  arb_gnt;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_src;
   logic        out_ready;
   logic        gnt_err;
`ifdef ARB_BUF_STATS_EN
   logic [31:0] grant_stats;
`endif

   arb_req_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .arb_req   (arb_req),
      .arb_en    (arb_en),
      .arb_gnt   (arb_gnt),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .gnt_err   (gnt_err)
`ifdef ARB_BUF_STATS_EN
      ,
      .grant_stats (grant_stats)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: one queue per channel plus the output-stage contents.
   logic [7:0] mq [4][$];
   logic       m_ov;
   logic [7:0] m_od;
   logic [1:0] m_os;
   logic       m_err;
   int         m_last;
   int         m_raw [4];

   function automatic logic [3:0] m_req();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (mq[i].size() != 0);
      return r;
   endfunction

   function automatic logic [3:0] m_rdy();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (mq[i].size() < DEPTH);
      return r;
   endfunction

   function automatic logic m_en();
      return !m_ov || out_ready;
   endfunction

   function automatic logic [3:0] arb_pick();
      logic [3:0] r;
      r = m_req();
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (m_last + k) % 4;
         if (r[c]) return 4'(1 << c);
      end
      return 4'b0000;
   endfunction

   task automatic model_step();
      logic       en;
      logic       ov0;
      logic       granted;
      logic [3:0] full;
      int         idx;
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            m_raw[i] = 0;
         end
         m_ov = 1'b0; m_od = 8'd0; m_os = 2'd0; m_err = 1'b0; m_last = 3;
         return;
      end
      en      = !m_ov || out_ready;
      ov0     = m_ov;
      granted = 1'b0;
      full    = ~m_rdy();
      idx     = 0;
      for (int i = 0; i < 4; i++) if (arb_gnt[i]) idx = i;
      if (en && $countones(arb_gnt) == 1 && mq[idx].size() > 0) begin
         m_od = mq[idx].pop_front();
         m_os = 2'(idx);
         m_ov = 1'b1;
         m_last = idx;
         m_raw[idx]++;
         granted = 1'b1;
      end
      if (en && arb_gnt != 4'd0 && !granted) m_err = 1'b1;
      if (!granted && ov0 && out_ready) m_ov = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (in_valid[i] && !full[i]) mq[i].push_back(in_data[8*i +: 8]);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g,
                        input logic r);
      in_valid = v; in_data = d; arb_gnt = g; out_ready = r;
      #1;
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(4'hF, $urandom, 4'b0000, 1'b1);
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      drive(4'b1000, 32'h5A00_0000, 4'b0000, 1'b1);
      tick();
      drive(4'b0000, 32'h0, 4'b1000, 1'b1);
      tick();
      reset = 1'b1;
      drive(4'hF, 32'hFFFF_FFFF, 4'b0001, 1'b1);
      tick();
      reset = 1'b0;
      drive(4'b0000, 32'h0, 4'b0000, 1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
      checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_out_src got=%0d exp=0", out_src); end
      checks++; if (gnt_err !== 1'b0) begin errors++; $display("FAIL reset_gnt_err got=%0b exp=0", gnt_err); end
      checks++; if (arb_req !== 4'b0000) begin errors++; $display("FAIL reset_arb_req got=%b exp=0000", arb_req); end
      checks++; if (in_ready !== 4'b1111) begin errors++; $display("FAIL reset_in_ready got=%b exp=1111", in_ready); end
      checks++; if (arb_en !== 1'b1) begin errors++; $display("FAIL reset_arb_en got=%0b exp=1", arb_en); end
      tick();
   endtask

   task automatic test_single();
      do_reset();
      drive(4'b0001, 32'h0000_00A5, 4'b0000, 1'b1);
      checks++; if (arb_req !== 4'b0000) begin errors++; $display("FAIL single_req_pre got=%b exp=0000", arb_req); end
      tick();
      drive(4'b0000, 32'h0, 4'b0001, 1'b1);
      checks++; if (arb_req !== 4'b0001) begin errors++; $display("FAIL single_req got=%b exp=0001", arb_req); end
      tick();
      drive(4'b0000, 32'h0, 4'b0000, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
      checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", out_data); end
      checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL single_src got=%0d exp=0", out_src); end
      checks++; if (arb_req !== 4'b0000) begin errors++; $display("FAIL single_empty got=%b exp=0000", arb_req); end
      tick();
   endtask

   task automatic test_full();
      do_reset();
      drive(4'b0001, 32'h0000_0011, 4'b0000, 1'b0);
      tick();
      drive(4'b0000, 32'h0, 4'b0001, 1'b0);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(4'b0100, (32'h20 + 32'(k)) << 16, 4'b0100, 1'b0);
         checks++; if (arb_en !== 1'b0) begin errors++; $display("FAIL full_arb_en k=%0d got=%0b exp=0", k, arb_en); end
         if (k == 4) begin
            checks++; if (in_ready[2] !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%0b exp=0", in_ready[2]); end
         end
         tick();
      end
      drive(4'b0000, 32'h0, 4'b0000, 1'b0);
      checks++; if (gnt_err !== 1'b0) begin errors++; $display("FAIL full_ignored_gnt got=%0b exp=0", gnt_err); end
      for (int k = 0; k < 4; k++) begin
         drive(4'b0000, 32'h0, 4'b0100, 1'b1);
         tick();
         drive(4'b0000, 32'h0, 4'b0000, 1'b0);
         checks++; if (out_data !== 8'(8'h20 + k) || out_src !== 2'd2) begin
            errors++; $display("FAIL full_drain k=%0d got=%h/%0d exp=%h/2", k, out_data, out_src, 8'(8'h20 + k));
         end
      end
      checks++; if (arb_req[2] !== 1'b0) begin errors++; $display("FAIL full_drop5 got=%0b exp=0", arb_req[2]); end
      drive(4'b0000, 32'h0, 4'b0000, 1'b1);
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int j = 0; j < 2; j++) begin
         drive(4'b1111, {8'h30 + 8'(j), 8'h20 + 8'(j), 8'h10 + 8'(j), 8'h00 + 8'(j)}, 4'b0000, 1'b1);
         tick();
      end
      for (int k = 0; k < 8; k++) begin
         drive(4'b0000, 32'h0, arb_pick(), 1'b1);
         tick();
         drive(4'b0000, 32'h0, 4'b0000, 1'b1);
         checks++; if (out_valid !== 1'b1 || out_src !== 2'(k % 4)) begin
            errors++; $display("FAIL b2b_src k=%0d got=%0b/%0d exp=1/%0d", k, out_valid, out_src, k % 4);
         end
         checks++; if (out_data !== m_od) begin errors++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, out_data, m_od); end
      end
      checks++; if (gnt_err !== 1'b0) begin errors++; $display("FAIL b2b_err got=%0b exp=0", gnt_err); end
      tick();
   endtask

   task automatic test_stall();
      do_reset();
      drive(4'b0010, 32'h0000_3000, 4'b0000, 1'b1);
      tick();
      drive(4'b0010, 32'h0000_3100, 4'b0000, 1'b1);
      tick();
      drive(4'b0000, 32'h0, 4'b0010, 1'b1);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(4'b0000, 32'h0, 4'b0010, 1'b0);
         checks++; if (out_valid !== 1'b1 || out_data !== 8'h30 || out_src !== 2'd1) begin
            errors++; $display("FAIL stall_hold k=%0d got=%0b/%h/%0d exp=1/30/1", k, out_valid, out_data, out_src);
         end
         checks++; if (arb_en !== 1'b0 || arb_req !== 4'b0010) begin
            errors++; $display("FAIL stall_en k=%0d got=%0b/%b exp=0/0010", k, arb_en, arb_req);
         end
         tick();
      end
      drive(4'b0000, 32'h0, 4'b0010, 1'b1);
      tick();
      drive(4'b0000, 32'h0, 4'b0000, 1'b1);
      checks++; if (out_data !== 8'h31 || arb_req !== 4'b0000) begin
         errors++; $display("FAIL stall_resume got=%h/%b exp=31/0000", out_data, arb_req);
      end
      tick();
   endtask

   task automatic test_gnt_err();
      do_reset();
      drive(4'b0110, 32'h0041_4000, 4'b0000, 1'b1);
      tick();
      drive(4'b0000, 32'h0, 4'b0110, 1'b1);
      tick();
      drive(4'b0000, 32'h0, 4'b0000, 1'b1);
      checks++; if (gnt_err !== 1'b1) begin errors++; $display("FAIL err_multi got=%0b exp=1", gnt_err); end
      checks++; if (arb_req !== 4'b0110 || out_valid !== 1'b0) begin
         errors++; $display("FAIL err_multi_nopop got=%b/%0b exp=0110/0", arb_req, out_valid);
      end
      tick();
      drive(4'b0000, 32'h0, 4'b0000, 1'b1);
      checks++; if (gnt_err !== 1'b1) begin errors++; $display("FAIL err_held got=%0b exp=1", gnt_err); end
      do_reset();
      drive(4'b0000, 32'h0, 4'b0000, 1'b1);
      checks++; if (gnt_err !== 1'b0) begin errors++; $display("FAIL err_reset got=%0b exp=0", gnt_err); end
      drive(4'b0001, 32'h0000_0042, 4'b0000, 1'b1);
      tick();
      drive(4'b0000, 32'h0, 4'b1000, 1'b1);
      tick();
      drive(4'b0000, 32'h0, 4'b0000, 1'b1);
      checks++; if (gnt_err !== 1'b1) begin errors++; $display("FAIL err_empty got=%0b exp=1", gnt_err); end
      checks++; if (arb_req !== 4'b0001 || out_valid !== 1'b0) begin
         errors++; $display("FAIL err_empty_nopop got=%b/%0b exp=0001/0", arb_req, out_valid);
      end
      tick();
   endtask

   task automatic test_random();
      logic [3:0] g;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         reset = (cyc == 300);
         g = arb_pick();
         if (cyc > 450 && $urandom_range(0, 15) == 0) g = 4'($urandom);
         drive(4'($urandom), $urandom, g, $urandom_range(0, 3) != 0);
         checks++; if (in_ready !== m_rdy()) begin errors++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", cyc, in_ready, m_rdy()); end
         checks++; if (arb_req !== m_req()) begin errors++; $display("FAIL rnd_arb_req c=%0d got=%b exp=%b", cyc, arb_req, m_req()); end
         checks++; if (arb_en !== m_en()) begin errors++; $display("FAIL rnd_arb_en c=%0d got=%0b exp=%0b", cyc, arb_en, m_en()); end
         checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_out_valid c=%0d got=%0b exp=%0b", cyc, out_valid, m_ov); end
         checks++; if (out_data !== m_od) begin errors++; $display("FAIL rnd_out_data c=%0d got=%h exp=%h", cyc, out_data, m_od); end
         checks++; if (out_src !== m_os) begin errors++; $display("FAIL rnd_out_src c=%0d got=%0d exp=%0d", cyc, out_src, m_os); end
         checks++; if (gnt_err !== m_err) begin errors++; $display("FAIL rnd_gnt_err c=%0d got=%0b exp=%0b", cyc, gnt_err, m_err); end
         tick();
      end
      reset = 1'b0;
   endtask

`ifdef ARB_BUF_STATS_EN
   task automatic test_stats();
      logic [31:0] exp_stats;
      int cyc;
      do_reset();
      cyc = 0;
      while (m_raw[1] < 300 && cyc < 2000) begin
         drive((cyc < 20) ? 4'b0011 : 4'b0010, $urandom, arb_pick(), 1'b1);
         tick();
         cyc++;
      end
      drive(4'b0000, 32'h0, 4'b0000, 1'b1);
      checks++; if (m_raw[1] < 300) begin errors++; $display("FAIL stats_timeout got=%0d exp=300", m_raw[1]); end
      for (int i = 0; i < 4; i++) exp_stats[8*i +: 8] = (m_raw[i] > 255) ? 8'd255 : 8'(m_raw[i]);
      checks++; if (grant_stats !== exp_stats) begin errors++; $display("FAIL stats_all got=%h exp=%h", grant_stats, exp_stats); end
      checks++; if (grant_stats[15:8] !== 8'hFF) begin errors++; $display("FAIL stats_sat got=%h exp=ff", grant_stats[15:8]); end
      tick();
   endtask
`endif

   initial begin
      reset = 1'b1; in_valid = 4'b0; in_data = 32'h0; arb_gnt = 4'b0; out_ready = 1'b1;
      m_ov = 1'b0; m_od = 8'd0; m_os = 2'd0; m_err = 1'b0; m_last = 3;
      for (int i = 0; i < 4; i++) m_raw[i] = 0;
      @(negedge clock);
      test_reset();
      test_single();
      test_full();
      test_back_to_back();
      test_stall();
      test_gnt_err();
      test_random();
`ifdef ARB_BUF_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "simulation time limit reached");
   end
endmodule
